mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the CPU's single shared data/program memory. It lets the CPU control path (fetch, LD, ST) and the program loader/debug port share one asynchronous-read SRAM. Each access is serialised through a fixed set-up/strobe/hold sequence so that the SRAM write enable never glitches. The CPU freezes its instruction pointer and instruction word while `cpu_req & !cpu_ack`.

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter_rr_pick2.sv | 28 ++
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the shared-SRAM arbiter: state encodings, port
// indices and default bus widths.
package mem_arbiter_pkg;

    localparam int AW_DEFAULT = 8;
    localparam int DW_DEFAULT = 8;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_WSET = 3'd2;
    localparam logic [2:0] ST_WSTB = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        RD   = ST_RD,
        WSET = ST_WSET,
        WSTB = ST_WSTB,
        DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the port that did not own the last
// transaction wins; the lock makes the CPU port ineligible.
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic req_cpu_i,
    input  logic req_ldr_i,
    input  logic last_owner_i,
    input  logic lock_i,
    output logic valid_o,
    output logic winner_o
);

    logic cpu_ok;

    always_comb begin
        cpu_ok  = req_cpu_i & ~lock_i;
        valid_o = cpu_ok | req_ldr_i;
        if (cpu_ok && req_ldr_i) begin
            winner_o = ~last_owner_i;
        end else if (req_ldr_i) begin
            winner_o = PORT_LDR;
        end else begin
            winner_o = PORT_CPU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// CPU / loader arbiter for one async-read SRAM. Every access runs a fixed
// set-up / strobe / hold sequence so the registered write strobe never glitches.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic [DW-1:0] cpu_rdata_o,
    output logic          cpu_ack_o,
    input  logic          ldr_req_i,
    input  logic          ldr_we_i,
    input  logic [AW-1:0] ldr_addr_i,
    input  logic [DW-1:0] ldr_wdata_i,
    output logic [DW-1:0] ldr_rdata_o,
    output logic          ldr_ack_o,
    input  logic          ldr_lock_i,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          mem_wen_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          busy_o,
    output logic          owner_o
);

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_wen_q, mem_wen_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;
    logic          pick_valid, pick_winner;
    logic          acc_we;

    rr_pick2 u_pick (
        .req_cpu_i    (cpu_req_i),
        .req_ldr_i    (ldr_req_i),
        .last_owner_i (owner_q),
        .lock_i       (ldr_lock_i),
        .valid_o      (pick_valid),
        .winner_o     (pick_winner)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wen_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        acc_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_winner;
                    if (pick_winner == PORT_LDR) begin
                        acc_we      = ldr_we_i;
                        mem_addr_d  = ldr_addr_i;
                        mem_wdata_d = ldr_wdata_i;
                    end else begin
                        acc_we      = cpu_we_i;
                        mem_addr_d  = cpu_addr_i;
                        mem_wdata_d = cpu_wdata_i;
                    end
                    state_d = acc_we ? WSET : RD;
                end
            end
            RD: begin
                if (owner_q == PORT_LDR) ldr_rdata_d = mem_rdata_i;
                else                     cpu_rdata_d = mem_rdata_i;
                state_d = DONE;
            end
            // Strobe is raised from the set-up cycle so it is a clean flop output in WSTB.
            WSET:    begin mem_wen_d = 1'b1; state_d = WSTB; end
            WSTB:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= PORT_LDR;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wen_q   <= 1'b0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wen_q   <= mem_wen_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
        end
    end

    assign cpu_ack_o   = (state_q == DONE) && (owner_q == PORT_CPU);
    assign ldr_ack_o   = (state_q == DONE) && (owner_q == PORT_LDR);
    assign busy_o      = (state_q != IDLE);
    assign owner_o     = owner_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wen_o   = mem_wen_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign ldr_rdata_o = ldr_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a vector table of single accesses plus hand-written
// sequences for round-robin, lock, mid-write reset and held requests.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_req = 1'b0, cpu_we = 1'b0, cpu_ack;
    logic [7:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
    logic       ldr_req = 1'b0, ldr_we = 1'b0, ldr_ack, ldr_lock = 1'b0;
    logic [7:0] ldr_addr = '0, ldr_wdata = '0, ldr_rdata;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_wen, busy, owner;

    logic [7:0] sram [256];

    mem_arbiter #(.AW(8), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack),
        .ldr_req_i(ldr_req), .ldr_we_i(ldr_we), .ldr_addr_i(ldr_addr),
        .ldr_wdata_i(ldr_wdata), .ldr_rdata_o(ldr_rdata), .ldr_ack_o(ldr_ack),
        .ldr_lock_i(ldr_lock),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wen_o(mem_wen),
        .mem_rdata_i(mem_rdata), .busy_o(busy), .owner_o(owner)
    );

    always #5 clk = ~clk;

    // SRAM model: async read, write on the edge that ends the strobe cycle.
    assign mem_rdata = sram[mem_addr];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) sram[i] <= 8'h00;
            sram[8'h10] <= 8'hA5;
            sram[8'h00] <= 8'h5A;
        end else if (mem_wen) begin
            sram[mem_addr] <= mem_wdata;
        end
    end

    typedef struct {
        logic       port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic       port;
        logic [7:0] rdata;
    } sb_t;

    sb_t        sbq[$];
    vec_t       vecs[10];
    int         nvec = 0, nerr = 0;
    int         cpu_acks = 0, ldr_acks = 0;
    bit         sb_on = 1'b1;
    logic [7:0] last_rd [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic at_pos();
        @(posedge clk);
        #1;
    endtask

    // One negedge sample; acks are counted and checked against the scoreboard here.
    task automatic tick();
        sb_t e;
        @(negedge clk);
        if (rst_n && (cpu_ack || ldr_ack)) begin
            if (cpu_ack) cpu_acks++;
            if (ldr_ack) ldr_acks++;
            check("ack_onehot", 32'(cpu_ack & ldr_ack), 0);
            if (sb_on) begin
                check("sb_nonempty", 32'(sbq.size() != 0), 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("sb_port", 32'(ldr_ack), 32'(e.port));
                    check("sb_owner", 32'(owner), 32'(e.port));
                    check("sb_rdata", 32'(e.port ? ldr_rdata : cpu_rdata), 32'(e.rdata));
                end
            end
        end
    endtask

    task automatic wait_ack(input logic port, input string nm);
        bit got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            tick();
            got = port ? ldr_ack : cpu_ack;
        end
        check(nm, 32'(got), 1);
    endtask

    task automatic drop_all();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drop_all();
        ldr_lock = 1'b0;
        sbq.delete();
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_mem_wen", 32'(mem_wen), 0);
        check("rst_rdata", 32'({cpu_rdata, ldr_rdata}), 0);
        check("rst_acks", 32'({cpu_ack, ldr_ack}), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_owner", 32'(owner), 1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic access(input vec_t v);
        int         cyc = 0, wen_at = 0, wen_n = 0;
        bit         stable = 1'b1, acked = 1'b0;
        logic [7:0] exp_rd;
        at_pos();
        exp_rd = v.we ? last_rd[v.port] : v.exp;
        if (!v.we) last_rd[v.port] = v.exp;
        sbq.push_back('{port: v.port, rdata: exp_rd});
        if (v.port) begin
            ldr_req = 1; ldr_we = v.we; ldr_addr = v.addr; ldr_wdata = v.wdata;
        end else begin
            cpu_req = 1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end
        while (!acked && cyc < 12) begin
            tick();
            cyc++;
            if (mem_wen) begin wen_n++; wen_at = cyc; end
            if (cyc >= 2 && (mem_addr !== v.addr || (v.we && mem_wdata !== v.wdata))) stable = 1'b0;
            acked = v.port ? ldr_ack : cpu_ack;
            // Once accepted, the request fields must no longer matter.
            if (cyc == 2) begin
                if (v.port) begin ldr_we = ~v.we; ldr_addr = ~v.addr; ldr_wdata = ~v.wdata; end
                else        begin cpu_we = ~v.we; cpu_addr = ~v.addr; cpu_wdata = ~v.wdata; end
            end
        end
        check("ack_latency", cyc, v.we ? 4 : 3);
        if (v.we) begin
            check("wen_cycles", wen_n, 1);
            check("wen_at", wen_at, 3);
        end else begin
            check("wen_on_read", wen_n, 0);
        end
        check("addr_data_stable", 32'(stable), 1);
        at_pos();
        drop_all();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  c0, l0;
        bit  seen, got;

        vecs[0] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5};
        vecs[1] = '{1'b1, 1'b1, 8'h20, 8'h3C, 8'h00};
        vecs[2] = '{1'b0, 1'b0, 8'h20, 8'h00, 8'h3C};
        vecs[3] = '{1'b0, 1'b1, 8'hFF, 8'h81, 8'h00};
        vecs[4] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h81};
        vecs[5] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h5A};
        vecs[6] = '{1'b0, 1'b1, 8'h00, 8'hC3, 8'h00};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'hC3};
        vecs[8] = '{1'b1, 1'b1, 8'h10, 8'h00, 8'h00};
        vecs[9] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h00};

        do_reset();
        for (int i = 0; i < 10; i++) access(vecs[i]);
        check("table_sb_drained", sbq.size(), 0);

        // Both ports requesting continuously: CPU wins the first tie, then alternation.
        do_reset();
        sbq.push_back('{port: 1'b0, rdata: 8'hA5});
        sbq.push_back('{port: 1'b1, rdata: 8'h5A});
        sbq.push_back('{port: 1'b0, rdata: 8'hA5});
        sbq.push_back('{port: 1'b1, rdata: 8'h5A});
        c0 = cpu_acks; l0 = ldr_acks;
        at_pos();
        cpu_req = 1; cpu_addr = 8'h10;
        ldr_req = 1; ldr_addr = 8'h00;
        for (int k = 0; k < 40 && (cpu_acks + ldr_acks - c0 - l0) < 4; k++) tick();
        at_pos();
        drop_all();
        check("rr_ack_count", cpu_acks + ldr_acks - c0 - l0, 4);
        check("rr_sb_drained", sbq.size(), 0);

        // Lock held with both requesting: only the loader is served.
        sb_on = 1'b0;
        c0 = cpu_acks; l0 = ldr_acks;
        at_pos();
        ldr_lock = 1;
        cpu_req = 1; cpu_addr = 8'h10;
        ldr_req = 1; ldr_addr = 8'h00;
        repeat (20) tick();
        check("lock_cpu_acks", cpu_acks - c0, 0);
        check("lock_ldr_acks", 32'((ldr_acks - l0) >= 5), 1);
        wait_ack(1'b1, "lock_ldr_ack_wait");
        at_pos();
        ldr_lock = 0;
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            tick();
            got = cpu_ack | ldr_ack;
        end
        check("post_lock_grant", 32'({cpu_ack, ldr_ack}), 32'(2'b10));
        at_pos();
        drop_all();
        sb_on = 1'b1;

        // Lock rises while the CPU read is in RD: the read still completes.
        sbq.push_back('{port: 1'b0, rdata: 8'hA5});
        sbq.push_back('{port: 1'b1, rdata: 8'h5A});
        at_pos();
        cpu_req = 1; cpu_addr = 8'h10;
        at_pos();
        ldr_lock = 1;
        ldr_req = 1; ldr_addr = 8'h00;
        wait_ack(1'b0, "lock_mid_cpu_ack");
        wait_ack(1'b1, "lock_mid_ldr_ack");
        at_pos();
        drop_all();
        ldr_lock = 0;
        check("lock_mid_sb_drained", sbq.size(), 0);

        // Reset during the strobe cycle drops mem_wen without a clock edge.
        sb_on = 1'b0;
        at_pos();
        ldr_req = 1; ldr_we = 1; ldr_addr = 8'h30; ldr_wdata = 8'h77;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            tick();
            seen = mem_wen;
        end
        check("wstb_reached", 32'(seen), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_wen", 32'(mem_wen), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_ack", 32'(ldr_ack), 0);
        check("async_rst_addr", 32'(mem_addr), 0);
        drop_all();
        l0 = ldr_acks;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick();
        check("abort_no_ack", ldr_acks - l0, 0);
        check("abort_idle", 32'(busy), 0);

        // Loader holds req through DONE: nothing starts in DONE, a new access starts in IDLE.
        c0 = cpu_acks; l0 = ldr_acks;
        at_pos();
        ldr_req = 1; ldr_addr = 8'h10;
        wait_ack(1'b1, "hold_first_ack");
        tick();
        check("no_start_in_done", 32'(busy), 0);
        tick();
        check("restart_in_idle", 32'(busy), 1);
        wait_ack(1'b1, "hold_second_ack");
        at_pos();
        drop_all();
        repeat (2) tick();
        check("hold_ldr_acks", ldr_acks - l0, 2);
        check("hold_cpu_acks", cpu_acks - c0, 0);
        check("idle_after_drop", 32'(busy), 0);
        check("hold_rdata", 32'(ldr_rdata), 32'h000000A5);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
